load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 186 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit bridging CPU byte/half/word requests onto a registered-read RAM.
// Misaligned loads become two word reads; misaligned stores become byte writes.
module load_store_unit #(
  parameter int MISALIGN_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        ram_we,
  output logic [31:0] ram_r_addr,
  output logic [31:0] ram_w_addr,
  output logic [31:0] ram_w_data,
  output logic [1:0]  ram_write_mode,
  output logic [1:0]  ram_read_mode,
  output logic        ram_read_signed,
  input  logic [31:0] ram_r_data
);
  localparam logic [1:0] RAM_MODE_BYTE = 2'd0;
  localparam logic [1:0] RAM_MODE_HALF = 2'd1;
  localparam logic [1:0] RAM_MODE_WORD = 2'd2;

  typedef enum logic [2:0] {
    IDLE, LD_ISSUE, LD_ISSUE_HI, LD_WAIT, ST_WRITE, ST_BYTES, ERR
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, lo_q, lo_d, rdata_q, rdata_d;
  logic [1:0]  size_q, size_d, cnt_q, cnt_d;
  logic        sgn_q, sgn_d, mis_q, mis_d, valid_q, valid_d, err_q, err_d;
  logic        req_mis, ram_we_c, st_last;
  logic [31:0] base_addr, win, mis_rdata;
  logic [7:0]  st_byte;

  assign req_mis   = (req_size == RAM_MODE_HALF && req_addr[1:0] == 2'd3) ||
                     (req_size == RAM_MODE_WORD && req_addr[1:0] != 2'd0);
  assign base_addr = {addr_q[31:2], 2'b00};
  assign st_last   = (size_q == RAM_MODE_HALF) ? (cnt_q == 2'd1) : (cnt_q == 2'd3);

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = valid_q;
  assign resp_err   = err_q;
  assign resp_rdata = rdata_q;
  // Reset gates the write strobe so an interrupted store cannot land on the reset edge.
  assign ram_we     = ram_we_c & ~rst;

  // Misaligned load: pick the byte window out of {hi word, lo word}.
  always_comb begin
    case (addr_q[1:0])
      2'd1:    win = {ram_r_data[7:0],  lo_q[31:8]};
      2'd2:    win = {ram_r_data[15:0], lo_q[31:16]};
      2'd3:    win = {ram_r_data[23:0], lo_q[31:24]};
      default: win = lo_q;
    endcase
    if (size_q == RAM_MODE_HALF)
      mis_rdata = sgn_q ? {{16{win[15]}}, win[15:0]} : {16'h0000, win[15:0]};
    else
      mis_rdata = win;
  end

  always_comb begin
    case (cnt_q)
      2'd1:    st_byte = wdata_q[15:8];
      2'd2:    st_byte = wdata_q[23:16];
      2'd3:    st_byte = wdata_q[31:24];
      default: st_byte = wdata_q[7:0];
    endcase
  end

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    size_d          = size_q;
    sgn_d           = sgn_q;
    mis_d           = mis_q;
    cnt_d           = cnt_q;
    lo_d            = lo_q;
    valid_d         = 1'b0;
    err_d           = 1'b0;
    rdata_d         = 32'h0;
    ram_we_c        = 1'b0;
    ram_r_addr      = 32'h0;
    ram_w_addr      = 32'h0;
    ram_w_data      = 32'h0;
    ram_write_mode  = RAM_MODE_WORD;
    ram_read_mode   = RAM_MODE_WORD;
    ram_read_signed = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          size_d  = req_size;
          sgn_d   = req_signed;
          mis_d   = req_mis;
          cnt_d   = 2'd0;
          if (req_size == 2'd3 || (req_mis && MISALIGN_EN == 0))
            state_d = ERR;
          else if (req_we)
            state_d = req_mis ? ST_BYTES : ST_WRITE;
          else
            state_d = LD_ISSUE;
        end
      end
      LD_ISSUE: begin
        ram_r_addr      = mis_q ? base_addr : addr_q;
        ram_read_mode   = mis_q ? RAM_MODE_WORD : size_q;
        ram_read_signed = mis_q ? 1'b0 : sgn_q;
        state_d         = mis_q ? LD_ISSUE_HI : LD_WAIT;
      end
      LD_ISSUE_HI: begin
        ram_r_addr = base_addr + 32'd4;
        lo_d       = ram_r_data;
        state_d    = LD_WAIT;
      end
      LD_WAIT: begin
        valid_d = 1'b1;
        rdata_d = mis_q ? mis_rdata : ram_r_data;
        state_d = IDLE;
      end
      ST_WRITE: begin
        ram_we_c       = 1'b1;
        ram_w_addr     = addr_q;
        ram_write_mode = size_q;
        ram_w_data     = wdata_q;
        valid_d        = 1'b1;
        state_d        = IDLE;
      end
      ST_BYTES: begin
        ram_we_c       = 1'b1;
        ram_w_addr     = addr_q + {30'h0, cnt_q};
        ram_write_mode = RAM_MODE_BYTE;
        ram_w_data     = {24'h0, st_byte};
        cnt_d          = cnt_q + 2'd1;
        if (st_last) begin
          cnt_d   = 2'd0;
          valid_d = 1'b1;
          state_d = IDLE;
        end
      end
      ERR: begin
        valid_d = 1'b1;
        err_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      size_q  <= 2'd0;
      sgn_q   <= 1'b0;
      mis_q   <= 1'b0;
      cnt_q   <= 2'd0;
      lo_q    <= 32'h0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      mis_q   <= mis_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array RAM model plus a byte-level reference memory.
module tb_load_store_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        ram_we, ram_read_signed;
  logic [31:0] ram_r_addr, ram_w_addr, ram_w_data, ram_r_data;
  logic [1:0]  ram_write_mode, ram_read_mode;

  logic        req_valid1, req_ready1, req_we1, req_signed1;
  logic [31:0] req_addr1, req_wdata1;
  logic [1:0]  req_size1;
  logic        resp_valid1, resp_err1;
  logic [31:0] resp_rdata1;
  logic        ram_we1, ram_read_signed1;
  logic [31:0] ram_r_addr1, ram_w_addr1, ram_w_data1;
  logic [31:0] ram_r_data1 = 32'hA5A5_A5A5;
  logic [1:0]  ram_write_mode1, ram_read_mode1;

  int checks = 0;
  int failures = 0;

  logic [7:0]  mem [512];
  logic [7:0]  model_mem [512];
  logic        poke_en = 1'b0;
  logic [31:0] poke_addr = 32'h0;
  logic [7:0]  poke_data = 8'h0;

  load_store_unit #(.MISALIGN_EN(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_signed(req_signed),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .ram_we(ram_we),
    .ram_r_addr(ram_r_addr), .ram_w_addr(ram_w_addr), .ram_w_data(ram_w_data),
    .ram_write_mode(ram_write_mode), .ram_read_mode(ram_read_mode),
    .ram_read_signed(ram_read_signed), .ram_r_data(ram_r_data)
  );

  load_store_unit #(.MISALIGN_EN(0)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1), .req_we(req_we1),
    .req_addr(req_addr1), .req_wdata(req_wdata1), .req_size(req_size1), .req_signed(req_signed1),
    .resp_valid(resp_valid1), .resp_rdata(resp_rdata1), .resp_err(resp_err1), .ram_we(ram_we1),
    .ram_r_addr(ram_r_addr1), .ram_w_addr(ram_w_addr1), .ram_w_data(ram_w_data1),
    .ram_write_mode(ram_write_mode1), .ram_read_mode(ram_read_mode1),
    .ram_read_signed(ram_read_signed1), .ram_r_data(ram_r_data1)
  );

  // Addresses used by the bench map without collision onto 512 bytes (low, 0x1xx, top-of-space).
  function automatic logic [8:0] idx(input logic [31:0] a);
    return a[8:0];
  endfunction

  function automatic logic [31:0] mem_read(input logic [31:0] a, input logic [1:0] m, input logic s);
    logic [31:0] v;
    v = {mem[idx(a + 32'd3)], mem[idx(a + 32'd2)], mem[idx(a + 32'd1)], mem[idx(a)]};
    if (m == 2'd0)      v = s ? {{24{v[7]}}, v[7:0]} : {24'h0, v[7:0]};
    else if (m == 2'd1) v = s ? {{16{v[15]}}, v[15:0]} : {16'h0, v[15:0]};
    return v;
  endfunction

  always @(posedge clk) begin
    ram_r_data <= mem_read(ram_r_addr, ram_read_mode, ram_read_signed);
    if (poke_en) begin
      mem[idx(poke_addr)] <= poke_data;
    end else if (ram_we) begin
      mem[idx(ram_w_addr)] <= ram_w_data[7:0];
      if (ram_write_mode != 2'd0) mem[idx(ram_w_addr + 32'd1)] <= ram_w_data[15:8];
      if (ram_write_mode == 2'd2) begin
        mem[idx(ram_w_addr + 32'd2)] <= ram_w_data[23:16];
        mem[idx(ram_w_addr + 32'd3)] <= ram_w_data[31:24];
      end
    end
  end

  // Reference load: gather n little-endian bytes starting at a (wrapping), then extend.
  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input logic sg);
    logic [31:0] v;
    int n;
    n = 1 << sz;
    v = 32'h0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = model_mem[idx(a + 32'(k))];
    if (n == 1 && sg && v[7])  v = v | 32'hFFFF_FF00;
    if (n == 2 && sg && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic put_byte(input logic [31:0] a, input logic [7:0] b);
    model_mem[idx(a)] = b;
    poke_en = 1'b1; poke_addr = a; poke_data = b;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  task automatic put_word(input logic [31:0] a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) put_byte(a + 32'(k), w[8*k +: 8]);
  endtask

  task automatic do_req(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] sz, input logic sg, input string nm,
                        output logic [31:0] got_rdata);
    int n, exp_lat, exp_nw, lat, nw;
    logic mis, exp_err, got_err, got_ready, idle_ok;
    logic [31:0] exp_rdata, base, ew_a, ew_d;
    logic [1:0]  ew_m;
    logic [31:0] w_a [8];
    logic [31:0] w_d [8];
    logic [1:0]  w_m [8];
    logic [31:0] r_a [8];
    logic [1:0]  r_m [8];
    logic        r_s [8];
    n = (sz == 2'd3) ? 0 : (1 << sz);
    mis = (sz == 2'd1 && a[1:0] == 2'd3) || (sz == 2'd2 && a[1:0] != 2'd0);
    exp_err = (sz == 2'd3);
    exp_rdata = 32'h0;
    exp_nw = 0;
    base = {a[31:2], 2'b00};
    if (exp_err) exp_lat = 1;
    else if (we) begin exp_lat = mis ? n : 1; exp_nw = mis ? n : 1; end
    else begin exp_lat = mis ? 3 : 2; exp_rdata = model_load(a, sz, sg); end

    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_size = sz; req_signed = sg;
    checks++;
    if (req_ready !== 1'b1) begin
      failures++; $display("FAIL %s ready_before_accept got=%b exp=1", nm, req_ready);
    end
    @(posedge clk); #1;
    lat = 0; nw = 0; got_rdata = 32'h0; got_err = 1'b0; got_ready = 1'b0; idle_ok = 1'b0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      r_a[i-1] = ram_r_addr; r_m[i-1] = ram_read_mode; r_s[i-1] = ram_read_signed;
      if (ram_we === 1'b1 && nw < 8) begin
        w_a[nw] = ram_w_addr; w_d[nw] = ram_w_data; w_m[nw] = ram_write_mode; nw++;
      end
      // Busy-time junk on the request port must be ignored.
      req_valid = 1'($urandom); req_we = 1'($urandom); req_addr = $urandom;
      req_wdata = $urandom; req_size = 2'($urandom); req_signed = 1'($urandom);
      @(posedge clk); #1;
      if (resp_valid === 1'b1) begin
        lat = i; got_rdata = resp_rdata; got_err = resp_err; got_ready = req_ready;
        idle_ok = (ram_we === 1'b0) && (ram_r_addr === 32'h0) && (ram_w_addr === 32'h0) &&
                  (ram_w_data === 32'h0) && (ram_write_mode === 2'd2) &&
                  (ram_read_mode === 2'd2) && (ram_read_signed === 1'b0);
        req_valid = 1'b0;
      end
    end
    if (lat == 0) req_valid = 1'b0;

    checks++;
    if (lat != exp_lat) begin failures++; $display("FAIL %s latency got=%0d exp=%0d", nm, lat, exp_lat); end
    checks++;
    if (got_err !== exp_err) begin failures++; $display("FAIL %s resp_err got=%b exp=%b", nm, got_err, exp_err); end
    checks++;
    if (got_rdata !== exp_rdata) begin
      failures++; $display("FAIL %s resp_rdata got=%08h exp=%08h", nm, got_rdata, exp_rdata);
    end
    checks++;
    if (got_ready !== 1'b1 || idle_ok !== 1'b1) begin
      failures++; $display("FAIL %s idle_at_resp ready=%b ram_idle=%b exp=1/1", nm, got_ready, idle_ok);
    end
    checks++;
    if (nw != exp_nw) begin failures++; $display("FAIL %s write_count got=%0d exp=%0d", nm, nw, exp_nw); end
    for (int k = 0; k < nw && k < exp_nw; k++) begin
      if (mis) begin ew_a = a + 32'(k); ew_m = 2'd0; ew_d = {24'h0, wd[8*k +: 8]}; end
      else     begin ew_a = a;          ew_m = sz;   ew_d = wd; end
      checks++;
      if (w_a[k] !== ew_a || w_m[k] !== ew_m || w_d[k] !== ew_d) begin
        failures++;
        $display("FAIL %s write%0d got=%08h/%0d/%08h exp=%08h/%0d/%08h", nm, k,
                 w_a[k], w_m[k], w_d[k], ew_a, ew_m, ew_d);
      end
    end
    if (!we && !exp_err && lat == exp_lat) begin
      checks++;
      if (mis) begin
        if (r_a[0] !== base || r_m[0] !== 2'd2 || r_a[1] !== base + 32'd4 || r_m[1] !== 2'd2) begin
          failures++;
          $display("FAIL %s split_reads got=%08h/%0d,%08h/%0d exp=%08h/2,%08h/2", nm,
                   r_a[0], r_m[0], r_a[1], r_m[1], base, base + 32'd4);
        end
      end else if (r_a[0] !== a || r_m[0] !== sz || r_s[0] !== sg) begin
        failures++;
        $display("FAIL %s native_read got=%08h/%0d/%b exp=%08h/%0d/%b", nm, r_a[0], r_m[0], r_s[0], a, sz, sg);
      end
    end
    if (we && !exp_err)
      for (int k = 0; k < n; k++) model_mem[idx(a + 32'(k))] = wd[8*k +: 8];
    $display("txn %s we=%b addr=%08h size=%0d sg=%b lat=%0d rdata=%08h err=%b", nm, we, a, sz, sg, lat, got_rdata, got_err);
  endtask

  task automatic dut1_req(input logic we, input logic [31:0] a, input logic [1:0] sz, input int exp_lat,
                          input logic exp_err, input logic [31:0] exp_rdata, input string nm);
    int lat, nw;
    logic [31:0] rd;
    logic er;
    req_valid1 = 1'b1; req_we1 = we; req_addr1 = a; req_size1 = sz; req_signed1 = 1'b0; req_wdata1 = $urandom;
    @(posedge clk); #1;
    req_valid1 = 1'b0; lat = 0; nw = 0; rd = 32'h0; er = 1'b0;
    for (int i = 1; i <= 6 && lat == 0; i++) begin
      if (ram_we1 === 1'b1) nw++;
      @(posedge clk); #1;
      if (resp_valid1 === 1'b1) begin lat = i; rd = resp_rdata1; er = resp_err1; end
    end
    checks++;
    if (lat != exp_lat || er !== exp_err || rd !== exp_rdata || nw != 0) begin
      failures++;
      $display("FAIL %s lat/err/rdata/writes got=%0d/%b/%08h/%0d exp=%0d/%b/%08h/0", nm, lat, er, rd, nw,
               exp_lat, exp_err, exp_rdata);
    end
    $display("txn %s addr=%08h size=%0d lat=%0d rdata=%08h err=%b", nm, a, sz, lat, rd, er);
  endtask

  task automatic test_reset();
    logic [7:0] b;
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_size = 2'd0; req_signed = 1'b0;
    req_valid1 = 1'b0; req_we1 = 1'b0; req_addr1 = 32'h0; req_wdata1 = 32'h0; req_size1 = 2'd0; req_signed1 = 1'b0;
    for (int i = 0; i < 512; i++) begin
      b = 8'($urandom);
      put_byte(32'(i), b);
    end
    for (int pass = 0; pass < 2; pass++) begin
      checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0) begin
        failures++;
        $display("FAIL reset_outputs ready/valid/err/rdata got=%b/%b/%b/%08h exp=1/0/0/00000000",
                 req_ready, resp_valid, resp_err, resp_rdata);
      end
      checks++;
      if (ram_we !== 1'b0 || ram_r_addr !== 32'h0 || ram_w_addr !== 32'h0 || ram_w_data !== 32'h0 ||
          ram_write_mode !== 2'd2 || ram_read_mode !== 2'd2 || ram_read_signed !== 1'b0) begin
        failures++;
        $display("FAIL reset_ram we=%b ra=%08h wa=%08h wd=%08h wm=%0d rm=%0d rs=%b exp=0/0/0/0/2/2/0",
                 ram_we, ram_r_addr, ram_w_addr, ram_w_data, ram_write_mode, ram_read_mode, ram_read_signed);
      end
      checks++;
      if (req_ready1 !== 1'b1 || resp_valid1 !== 1'b0) begin
        failures++; $display("FAIL reset_dut1 ready/valid got=%b/%b exp=1/0", req_ready1, resp_valid1);
      end
      rst = 1'b0;
      @(posedge clk); #1;
    end
    $display("txn reset done");
  endtask

  task automatic test_aligned();
    logic [31:0] rd;
    do_req(1'b1, 32'h100, 32'h1122_3344, 2'd2, 1'b0, "st_word_aligned", rd);
    do_req(1'b0, 32'h100, 32'h0, 2'd2, 1'b0, "ld_word_aligned", rd);
    checks++;
    if (rd !== 32'h1122_3344) begin failures++; $display("FAIL ld_word_const got=%08h exp=11223344", rd); end
  endtask

  task automatic test_misaligned_load();
    logic [31:0] rd;
    put_word(32'h104, 32'h5566_7788);
    do_req(1'b0, 32'h102, 32'h0, 2'd2, 1'b0, "ld_word_off2", rd);
    checks++;
    if (rd !== 32'h7788_1122) begin failures++; $display("FAIL ld_word_off2_const got=%08h exp=77881122", rd); end
    do_req(1'b0, 32'h103, 32'h0, 2'd1, 1'b1, "ld_half_off3_s", rd);
    checks++;
    if (rd !== 32'hFFFF_8811) begin failures++; $display("FAIL ld_half_s_const got=%08h exp=ffff8811", rd); end
    do_req(1'b0, 32'h103, 32'h0, 2'd1, 1'b0, "ld_half_off3_u", rd);
    checks++;
    if (rd !== 32'h0000_8811) begin failures++; $display("FAIL ld_half_u_const got=%08h exp=00008811", rd); end
  endtask

  task automatic test_wrap();
    logic [31:0] rd;
    do_req(1'b0, 32'hFFFF_FFFE, 32'h0, 2'd2, 1'b0, "ld_word_wrap", rd);
    do_req(1'b1, 32'hFFFF_FFFF, 32'hA1B2_C3D4, 2'd2, 1'b0, "st_word_wrap", rd);
    do_req(1'b0, 32'hFFFF_FFFF, 32'h0, 2'd2, 1'b0, "ld_word_wrap3", rd);
  endtask

  task automatic test_misaligned_store();
    logic [31:0] rd;
    do_req(1'b1, 32'h103, 32'h0000_BEEF, 2'd1, 1'b0, "st_half_off3", rd);
    do_req(1'b0, 32'h103, 32'h0, 2'd1, 1'b0, "ld_half_back", rd);
    checks++;
    if (rd !== 32'h0000_BEEF) begin failures++; $display("FAIL st_half_readback got=%08h exp=0000beef", rd); end
  endtask

  task automatic test_error();
    logic [31:0] rd;
    do_req(1'b1, 32'h100, 32'hDEAD_BEEF, 2'd3, 1'b0, "st_size3", rd);
    do_req(1'b0, 32'h100, 32'h0, 2'd3, 1'b1, "ld_size3", rd);
  endtask

  task automatic test_no_misalign();
    dut1_req(1'b0, 32'h101, 2'd2, 1, 1'b1, 32'h0, "nomis_ld_word_101");
    dut1_req(1'b1, 32'h103, 2'd1, 1, 1'b1, 32'h0, "nomis_st_half_103");
    dut1_req(1'b0, 32'h104, 2'd2, 2, 1'b0, 32'hA5A5_A5A5, "nomis_ld_word_104");
  endtask

  task automatic test_reset_mid_store();
    logic [31:0] rd;
    int bad;
    put_word(32'h105, 32'h0102_0304);
    put_word(32'h109, 32'h0506_0708);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h105; req_wdata = 32'hCAFE_F00D;
    req_size = 2'd2; req_signed = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if (ram_we !== 1'b0) begin failures++; $display("FAIL rst_gates_we got=%b exp=0", ram_we); end
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      failures++; $display("FAIL rst_mid_store ready/valid got=%b/%b exp=1/0", req_ready, resp_valid);
    end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (ram_we !== 1'b0 || resp_valid !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL rst_mid_store_quiet got=%0d exp=0", bad); end
    model_mem[idx(32'h105)] = 8'h0D;
    model_mem[idx(32'h106)] = 8'hF0;
    $display("txn reset_mid_store bad_cycles=%0d", bad);
    do_req(1'b0, 32'h105, 32'h0, 2'd2, 1'b0, "ld_after_rst", rd);
    do_req(1'b1, 32'h10A, 32'h1357_9BDF, 2'd2, 1'b0, "st_word_after_rst", rd);
    do_req(1'b0, 32'h10A, 32'h0, 2'd2, 1'b0, "ld_word_after_rst", rd);
  endtask

  task automatic test_random_back_to_back();
    logic [31:0] a, rd;
    for (int t = 0; t < 200; t++) begin
      if ($urandom_range(0, 3) != 0) a = 32'h100 + 32'($urandom_range(0, 56));
      else                           a = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
      do_req(1'($urandom), a, $urandom, 2'($urandom), 1'($urandom), "rand", rd);
    end
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_misaligned_load();
    test_wrap();
    test_misaligned_store();
    test_error();
    test_no_misalign();
    test_reset_mid_store();
    test_random_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
